// File: rtl/fcpu_pkg.sv
// fcpu_pkg: shared constants and types for the fcpu top level, including
// the code-RAM loader state encoding and its checksum helper.
package fcpu_pkg;

  localparam int DATA_W         = 32;
  localparam int CRAM_ADDR_W    = 8;
  localparam int CRAM_HDR_BYTES = 2;
  localparam int CRAM_CNT_W     = 16;

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    DATA  = 3'd2,
    CKSUM = 3'd3,
    RUN   = 3'd4,
    ERR   = 3'd5
  } cram_ld_state_t;

  // One step of the running frame checksum (byte-wise XOR).
  function automatic logic [7:0] cram_cksum_step(input logic [7:0] acc,
                                                 input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/fcpu_cram_mem.sv
// fcpu_cram_mem: simple dual-port code RAM, one write port and one
// registered read-first read port. Contents power up as zero and are
// deliberately not touched by rst; only the read register is cleared.
module fcpu_cram_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  import fcpu_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH] = '{default: {DATA_W{1'b0}}};
  logic [DATA_W-1:0] rd_data_r;

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port: registered; a same-cycle write is not visible (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fcpu_cram_loader.sv
// fcpu_cram_loader: code RAM loaded from a byte stream at run time.
// Frame: 16-bit big-endian word count N, then N words MSB first, then
// (only with FCPU_CRAM_CKSUM_EN defined) one XOR checksum byte covering
// every preceding frame byte. The core is held in core_rst until RUN.
module fcpu_cram_loader #(
  parameter int DATA_W = fcpu_pkg::DATA_W,
  parameter int ADDR_W = fcpu_pkg::CRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              core_rst,
  output logic              load_done,
  output logic              err
);
  import fcpu_pkg::*;

  localparam int BYTES  = DATA_W / 8;
  localparam int BPTR_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BPTR_W-1:0] BPTR_LAST = BPTR_W'(BYTES - 1);

`ifdef FCPU_CRAM_CKSUM_EN
  localparam cram_ld_state_t AFTER_DATA = CKSUM;
`else
  localparam cram_ld_state_t AFTER_DATA = RUN;
`endif

  // Elaboration-time parameter sanity.
  generate
    if ((DATA_W < 8) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
      $error("fcpu_cram_loader: DATA_W must be a positive multiple of 8");
    end
    if (CRAM_CNT_W != (8 * CRAM_HDR_BYTES)) begin : g_bad_hdr
      $error("fcpu_cram_loader: word count width must match header bytes");
    end
  endgenerate

  cram_ld_state_t      state_r;
  cram_ld_state_t      state_nxt_s;
  logic                ld_ready_s;
  logic                hs_s;
  logic                last_byte_s;
  logic                last_word_s;
  logic                wr_en_s;
  logic                reload_go_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic [CRAM_CNT_W-1:0] n_hdr_s;

  logic [BPTR_W-1:0]     byte_ptr_r;
  logic [CRAM_CNT_W-1:0] word_cnt_r;
  logic [CRAM_CNT_W-1:0] word_n_r;
  logic [ADDR_W-1:0]     wr_addr_r;
  logic [DATA_W-1:0]     word_r;
  logic                  core_rst_r;
  logic                  load_done_r;

`ifdef FCPU_CRAM_CKSUM_EN
  logic [7:0]            xor_r;
  logic                  err_r;
`endif

  // The loader accepts bytes in every framing state; never in RUN or ERR.
  always_comb begin
    ld_ready_s = 1'b0;
    case (state_r)
      HDR0, HDR1, DATA, CKSUM: ld_ready_s = 1'b1;
      default:                 ld_ready_s = 1'b0;
    endcase
  end

  assign hs_s        = ld_valid & ld_ready_s;
  assign last_byte_s = (byte_ptr_r == BPTR_LAST);
  // Widened by one bit so N = 0xFFFF cannot alias through a wrap.
  assign last_word_s = (({1'b0, word_cnt_r} + {{CRAM_CNT_W{1'b0}}, 1'b1})
                        == {1'b0, word_n_r});
  assign n_hdr_s     = {word_n_r[CRAM_CNT_W-1:8], ld_data};
  // The word being written includes the byte accepted this cycle.
  assign wr_data_s   = (word_r << 4'd8) | DATA_W'(ld_data);

  // Next-state decode and write strobe for the framing FSM.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    reload_go_s = 1'b0;
    case (state_r)
      HDR0: begin
        if (hs_s) begin
          state_nxt_s = HDR1;
        end else begin
          state_nxt_s = HDR0;
        end
      end
      HDR1: begin
        if (hs_s && (n_hdr_s == {CRAM_CNT_W{1'b0}})) begin
          state_nxt_s = AFTER_DATA;
        end else if (hs_s) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = HDR1;
        end
      end
      DATA: begin
        if (hs_s && last_byte_s) begin
          wr_en_s = 1'b1;
          if (last_word_s) begin
            state_nxt_s = AFTER_DATA;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
`ifdef FCPU_CRAM_CKSUM_EN
      CKSUM: begin
        if (hs_s && (ld_data == xor_r)) begin
          state_nxt_s = RUN;
        end else if (hs_s) begin
          state_nxt_s = ERR;
        end else begin
          state_nxt_s = CKSUM;
        end
      end
`endif
      RUN, ERR: begin
        if (reload) begin
          state_nxt_s = HDR0;
          reload_go_s = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = HDR0;
    endcase
  end

  // State register; rst overrides any simultaneous reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= HDR0;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Framing datapath: header capture, byte assembly, address/count tracking.
  always_ff @(posedge clk) begin
    if (rst || reload_go_s) begin
      byte_ptr_r <= {BPTR_W{1'b0}};
      word_cnt_r <= {CRAM_CNT_W{1'b0}};
      word_n_r   <= {CRAM_CNT_W{1'b0}};
      wr_addr_r  <= {ADDR_W{1'b0}};
      word_r     <= {DATA_W{1'b0}};
`ifdef FCPU_CRAM_CKSUM_EN
      xor_r      <= 8'h00;
`endif
    end else if (hs_s) begin
`ifdef FCPU_CRAM_CKSUM_EN
      xor_r <= cram_cksum_step(xor_r, ld_data);
`endif
      case (state_r)
        HDR0: word_n_r <= {ld_data, {(CRAM_CNT_W - 8){1'b0}}};
        HDR1: word_n_r <= n_hdr_s;
        DATA: begin
          word_r <= wr_data_s;
          if (last_byte_s) begin
            byte_ptr_r <= {BPTR_W{1'b0}};
            word_cnt_r <= word_cnt_r + CRAM_CNT_W'(1'b1);
            wr_addr_r  <= wr_addr_r + ADDR_W'(1'b1);
          end else begin
            byte_ptr_r <= byte_ptr_r + BPTR_W'(1'b1);
          end
        end
        default: word_r <= word_r;
      endcase
    end
  end

  // Status outputs registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst_r  <= 1'b1;
      load_done_r <= 1'b0;
`ifdef FCPU_CRAM_CKSUM_EN
      err_r       <= 1'b0;
`endif
    end else begin
      core_rst_r  <= (state_nxt_s != RUN);
      load_done_r <= (state_nxt_s == RUN);
`ifdef FCPU_CRAM_CKSUM_EN
      err_r       <= (state_nxt_s == ERR);
`endif
    end
  end

  fcpu_cram_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_r),
    .wr_data (wr_data_s),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign ld_ready  = ld_ready_s;
  assign core_rst  = core_rst_r;
  assign load_done = load_done_r;
`ifdef FCPU_CRAM_CKSUM_EN
  assign err       = err_r;
`else
  assign err       = 1'b0;
`endif

endmodule
